tx_resp_arbiter: RTL and testbench
==================================

// Module: tx_resp_arbiter
// PURPOSE
// Shares the single write port of the TX async FIFO (REF_CLK domain) between three response sources:
// register-file read data (1 byte), ALU result (2 bytes, LSB first) and error/status codes (1 byte).
// Each source has a one-entry holding slot. A round-robin FSM drains the slots into the FIFO.
// FIFO_FULL backpressure is honoured, so the system controller never stalls on a full FIFO.
// PARAMETERS
// DATA_WIDTH  8   FIFO/RF byte width
// ALU_WIDTH   16  ALU result width; fixed at 2*DATA_WIDTH
// PORTS
// CLK          in   1           REF_CLK domain clock
// RST          in   1           asynchronous, active-low reset (already synchronised upstream)
// RF_RD_DATA   in   DATA_WIDTH  register-file read data
// RF_RD_VLD    in   1           1-cycle pulse; RF_RD_DATA valid
// ALU_OUT      in   ALU_WIDTH   ALU result
// ALU_OUT_VLD  in   1           1-cycle pulse; ALU_OUT valid
// ERR_CODE     in   DATA_WIDTH  error/status byte
// ERR_VLD      in   1           1-cycle pulse; ERR_CODE valid
// FIFO_FULL    in   1           FIFO write-side full flag
// WR_DATA      out  DATA_WIDTH  FIFO write data (registered)
// WR_INC       out  1           FIFO write strobe; one byte is written per high cycle
// BUSY         out  1           any slot occupied or FSM not in IDLE
// OVF          out  1           1-cycle pulse: a VLD arrived for an occupied slot and was dropped
// BEHAVIOUR
// - Reset values: slots empty, FSM=IDLE, rr pointer=RF, WR_DATA=0, WR_INC=0, BUSY=0, OVF=0.
// - Slot capture: at the edge ending a cycle with xx_VLD=1, the data is stored if the slot is empty
//   or is being released that same cycle. Otherwise the new data is dropped, OVF=1 next cycle, held data unchanged.
// - FSM states: IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI, SEND_ERR.
// - IDLE: if any slot is full, pick the winner round-robin.
//   Order RF->ALU->ERR; the search starts at the source after the last granted one.
//   Load WR_DATA with the winner's byte (ALU: ALU_OUT[7:0]); go to SEND_x. With no slot full, stay in IDLE.
// - SEND_x: WR_INC = ~FIFO_FULL (combinational); WR_DATA is held stable.
//   A cycle with WR_INC=1 completes the byte.
// - On completion: SEND_RF/SEND_ERR release the slot, update the rr pointer and go to IDLE.
//   SEND_ALU_LO loads ALU_OUT[15:8] into WR_DATA and goes to SEND_ALU_HI (slot still held).
//   SEND_ALU_HI releases the ALU slot, updates the pointer and goes to IDLE.
// - FIFO_FULL=1 in SEND_x: WR_INC=0; state and WR_DATA are held indefinitely. No byte is lost or duplicated.
// - Latency: VLD in cycle n -> earliest WR_INC in cycle n+2 (capture, IDLE select, send).
//   Peak rate is 1 byte per 2 cycles (IDLE between grants). The ALU HI byte follows LO back-to-back.
// - The ALU byte pair is never interleaved with another source; LSB is always written first.
// - Simultaneous VLDs on different sources: all are captured; grant order follows the rr pointer.
// - Release and a new VLD on the same slot in the same cycle: the new data is captured, no OVF.
// - Reset mid-operation: in-flight bytes and slots are discarded immediately.
//   A half-sent ALU pair loses its MSB (accepted; host retries).
// STRUCTURE
// - Shared defs header tx_resp_defs: FSM state encodings, requester IDs (REQ_RF=0, REQ_ALU=1, REQ_ERR=2).
// - Sub-module rr_arb3: 3-request round-robin select. Inputs: req[2:0], last grant. Output: one-hot gnt.
//   Combinational; the pointer register stays in tx_resp_arbiter.
// - Top: three slot registers + valid flags, FSM, WR_DATA register, OVF register.
// TESTING
// 1 Reset: RST=0 mid-ALU-send -> WR_INC=0, BUSY=0, OVF=0, WR_DATA=0; no write after release.
// 2 RF_RD_VLD, RF_RD_DATA=8'hA5, FIFO_FULL=0 -> WR_INC high exactly 1 cycle, 2 cycles later, WR_DATA=A5.
// 3 ALU_OUT_VLD, ALU_OUT=16'h1234 -> two consecutive WR_INC cycles with 8'h34 then 8'h12.
// 4 RF(8'h01), ALU(16'hBEEF), ERR(8'hEE) valid same cycle -> FIFO writes 01,EF,BE,EE.
//   Then a second burst starts at the source after ERR (RF).
// 5 FIFO_FULL=1 for 10 cycles during SEND_ALU_HI -> WR_INC=0, WR_DATA=BE held; one write when FULL drops.
// 6 Two RF_RD_VLD (8'h11, 8'h22) while FIFO_FULL=1 -> 8'h22 dropped, OVF pulse 1 cycle, only 11 written.

Source files
------------

// File: rtl/tx_resp_defs.sv
// Shared definitions for the TX response arbiter: FSM encoding and requester IDs.
package tx_resp_defs;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_RF     = 3'd1,
        ST_SEND_ALU_LO = 3'd2,
        ST_SEND_ALU_HI = 3'd3,
        ST_SEND_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] REQ_RF  = 2'd0;
    localparam logic [1:0] REQ_ALU = 2'd1;
    localparam logic [1:0] REQ_ERR = 2'd2;

    function automatic logic [1:0] next_req(input logic [1:0] r);
        return (r == REQ_ERR) ? REQ_RF : r + 2'd1;
    endfunction

    function automatic logic [1:0] prev_req(input logic [1:0] r);
        return (r == REQ_RF) ? REQ_ERR : r - 2'd1;
    endfunction

endpackage

// File: rtl/tx_resp_arbiter_rr_arb3.sv
// Three-way round-robin select: the search starts at the requester after `last`.
module rr_arb3
    import tx_resp_defs::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    logic [1:0] idx;

    always_comb begin
        gnt = '0;
        idx = last;
        for (int i = 0; i < 3; i++) begin
            idx = next_req(idx);
            if (req[idx] && (gnt == '0))
                gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tx_resp_arbiter.sv
// Drains three one-entry response slots (RF byte, ALU word, error byte) into the
// TX FIFO write port, round-robin, honouring FIFO_FULL backpressure.
module tx_resp_arbiter
    import tx_resp_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic [DATA_WIDTH-1:0] ERR_CODE,
    input  logic                  ERR_VLD,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  BUSY,
    output logic                  OVF
);

    logic                  rf_full, alu_full, err_full;
    logic [DATA_WIDTH-1:0] rf_data, err_data;
    logic [ALU_WIDTH-1:0]  alu_data;
    state_e                state;
    logic [1:0]            rr_ptr;   // next source to search from
    logic [2:0]            gnt;
    logic                  rel_rf, rel_alu, rel_err;

    assign WR_INC  = (state != ST_IDLE) && !FIFO_FULL;
    assign rel_rf  = WR_INC && (state == ST_SEND_RF);
    assign rel_alu = WR_INC && (state == ST_SEND_ALU_HI);
    assign rel_err = WR_INC && (state == ST_SEND_ERR);
    assign BUSY    = rf_full || alu_full || err_full || (state != ST_IDLE);

    rr_arb3 u_arb (
        .req  ({err_full, alu_full, rf_full}),
        .last (prev_req(rr_ptr)),
        .gnt  (gnt)
    );

    // A slot accepts new data when empty or when it is being released this cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rf_full  <= 1'b0;
            alu_full <= 1'b0;
            err_full <= 1'b0;
            rf_data  <= '0;
            alu_data <= '0;
            err_data <= '0;
            OVF      <= 1'b0;
        end else begin
            OVF <= (RF_RD_VLD   && rf_full  && !rel_rf)  ||
                   (ALU_OUT_VLD && alu_full && !rel_alu) ||
                   (ERR_VLD     && err_full && !rel_err);

            if (RF_RD_VLD && (!rf_full || rel_rf)) begin
                rf_full <= 1'b1;
                rf_data <= RF_RD_DATA;
            end else if (rel_rf) begin
                rf_full <= 1'b0;
            end

            if (ALU_OUT_VLD && (!alu_full || rel_alu)) begin
                alu_full <= 1'b1;
                alu_data <= ALU_OUT;
            end else if (rel_alu) begin
                alu_full <= 1'b0;
            end

            if (ERR_VLD && (!err_full || rel_err)) begin
                err_full <= 1'b1;
                err_data <= ERR_CODE;
            end else if (rel_err) begin
                err_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            rr_ptr  <= REQ_RF;
            WR_DATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[REQ_RF]) begin
                        WR_DATA <= rf_data;
                        state   <= ST_SEND_RF;
                    end else if (gnt[REQ_ALU]) begin
                        WR_DATA <= alu_data[DATA_WIDTH-1:0];
                        state   <= ST_SEND_ALU_LO;
                    end else if (gnt[REQ_ERR]) begin
                        WR_DATA <= err_data;
                        state   <= ST_SEND_ERR;
                    end
                end
                ST_SEND_RF: if (WR_INC) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_req(REQ_RF);
                end
                ST_SEND_ALU_LO: if (WR_INC) begin
                    WR_DATA <= alu_data[ALU_WIDTH-1:DATA_WIDTH];
                    state   <= ST_SEND_ALU_HI;
                end
                ST_SEND_ALU_HI: if (WR_INC) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_req(REQ_ALU);
                end
                ST_SEND_ERR: if (WR_INC) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_req(REQ_ERR);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Randomised + directed bench for tx_resp_arbiter against a byte-queue reference model.
module tb_tx_resp_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RF_RD_DATA = '0;
    logic        RF_RD_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic [7:0]  ERR_CODE = '0;
    logic        ERR_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [7:0]  WR_DATA;
    logic        WR_INC, BUSY, OVF;

    tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .ERR_CODE(ERR_CODE), .ERR_VLD(ERR_VLD),
        .FIFO_FULL(FIFO_FULL),
        .WR_DATA(WR_DATA), .WR_INC(WR_INC), .BUSY(BUSY), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: slot contents plus the byte sequence of the grant in progress.
    bit          occ [3];
    logic [15:0] sd  [3];
    logic [7:0]  pq  [$];
    int          owner, ptr;
    logic [7:0]  wd;
    logic        ovf_m;
    logic [7:0]  wlog [$];
    int          wcyc [$];
    int          cyc_no = 0;

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin occ[s] = 0; sd[s] = '0; end
        pq.delete();
        owner = 0; ptr = 0; wd = '0; ovf_m = 1'b0;
    endtask

    task automatic cyc(input bit rv, input logic [7:0] rd, input bit av, input logic [15:0] ad,
                       input bit ev, input logic [7:0] ed, input bit full);
        bit was_idle;
        bit v [3];
        logic [15:0] nd [3];
        RF_RD_VLD = rv; RF_RD_DATA = rd;
        ALU_OUT_VLD = av; ALU_OUT = ad;
        ERR_VLD = ev; ERR_CODE = ed;
        FIFO_FULL = full;
        @(negedge CLK);
        chk("wr_inc",  WR_INC, (pq.size() > 0 && !full));
        chk("wr_data", WR_DATA, wd);
        chk("busy",    BUSY, (occ[0] || occ[1] || occ[2] || pq.size() > 0));
        chk("ovf",     OVF, ovf_m);
        if (WR_INC) begin wlog.push_back(WR_DATA); wcyc.push_back(cyc_no); end
        @(posedge CLK);
        v[0] = rv; v[1] = av; v[2] = ev;
        nd[0] = {8'h00, rd}; nd[1] = ad; nd[2] = {8'h00, ed};
        was_idle = (pq.size() == 0);
        if (!was_idle && !full) begin
            void'(pq.pop_front());
            if (pq.size() == 0) begin
                occ[owner] = 0;
                ptr = (owner + 1) % 3;
            end else begin
                wd = pq[0];
            end
        end else if (was_idle) begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (ptr + k) % 3;
                if (occ[s] && pq.size() == 0) begin
                    owner = s;
                    pq.push_back(sd[s][7:0]);
                    if (s == 1) pq.push_back(sd[s][15:8]);
                    wd = pq[0];
                end
            end
        end
        ovf_m = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (v[s]) begin
                if (!occ[s]) begin occ[s] = 1; sd[s] = nd[s]; end
                else ovf_m = 1'b1;
            end
        end
        cyc_no++;
        #1;
    endtask

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 16'h0000, 0, 8'h00, full);
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b0;
        RF_RD_VLD = 0; ALU_OUT_VLD = 0; ERR_VLD = 0; FIFO_FULL = 0;
        #1;
        chk("rst_wr_inc",  WR_INC, 0);
        chk("rst_busy",    BUSY, 0);
        chk("rst_ovf",     OVF, 0);
        chk("rst_wr_data", WR_DATA, 0);
        model_reset();
        wlog.delete(); wcyc.delete();
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        int t0;
        model_reset();
        #3;
        chk("init_wr_inc",  WR_INC, 0);
        chk("init_busy",    BUSY, 0);
        chk("init_ovf",     OVF, 0);
        chk("init_wr_data", WR_DATA, 0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // single RF byte: write exactly once, two cycles after VLD
        t0 = cyc_no;
        cyc(1, 8'hA5, 0, 0, 0, 0, 0);
        idle(6, 0);
        chk("t2_cnt", wlog.size(), 1);
        chk("t2_byte", wlog[0], 8'hA5);
        chk("t2_lat", wcyc[0], t0 + 2);

        // ALU pair: LSB then MSB on consecutive cycles
        wlog.delete(); wcyc.delete();
        cyc(0, 0, 1, 16'h1234, 0, 0, 0);
        idle(6, 0);
        chk("t3_cnt", wlog.size(), 2);
        chk("t3_lo", wlog[0], 8'h34);
        chk("t3_hi", wlog[1], 8'h12);
        chk("t3_b2b", wcyc[1] - wcyc[0], 1);

        // simultaneous requests after reset
        do_reset();
        cyc(1, 8'h01, 1, 16'hBEEF, 1, 8'hEE, 0);
        idle(10, 0);
        chk("t4_cnt", wlog.size(), 4);
        chk("t4_b0", wlog[0], 8'h01);
        chk("t4_b1", wlog[1], 8'hEF);
        chk("t4_b2", wlog[2], 8'hBE);
        chk("t4_b3", wlog[3], 8'hEE);
        wlog.delete(); wcyc.delete();
        cyc(1, 8'h02, 1, 16'hCAFE, 1, 8'hDD, 0);
        idle(10, 0);
        chk("t4b_cnt", wlog.size(), 4);
        chk("t4b_b0", wlog[0], 8'h02);
        chk("t4b_b3", wlog[3], 8'hDD);

        // FIFO full while the ALU MSB is pending
        wlog.delete(); wcyc.delete();
        cyc(0, 0, 1, 16'hBEEF, 0, 0, 0);
        for (int i = 0; i < 10 && !(pq.size() == 1 && owner == 1); i++) idle(1, 0);
        for (int i = 0; i < 10; i++) begin
            idle(1, 1);
            chk("t5_hold", WR_DATA, 8'hBE);
        end
        idle(4, 0);
        chk("t5_cnt", wlog.size(), 2);
        chk("t5_lo", wlog[0], 8'hEF);
        chk("t5_hi", wlog[1], 8'hBE);

        // overflow on an occupied RF slot
        wlog.delete(); wcyc.delete();
        cyc(1, 8'h11, 0, 0, 0, 0, 1);
        cyc(1, 8'h22, 0, 0, 0, 0, 1);
        chk("t6_ovf_hi", OVF, 1);
        idle(3, 1);
        chk("t6_ovf_lo", OVF, 0);
        idle(5, 0);
        chk("t6_cnt", wlog.size(), 1);
        chk("t6_byte", wlog[0], 8'h11);

        // reset in the middle of an ALU send
        cyc(0, 0, 1, 16'h5678, 0, 0, 0);
        for (int i = 0; i < 10 && !(pq.size() == 1 && owner == 1); i++) idle(1, 0);
        idle(2, 1);
        do_reset();
        idle(8, 0);
        chk("t1_no_wr", wlog.size(), 0);

        // randomised traffic with bursty backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(3) == 0), 8'($urandom),
                ($urandom_range(3) == 0), 16'($urandom),
                ($urandom_range(3) == 0), 8'($urandom),
                ($urandom_range(2) == 0));
        end
        idle(20, 0);
        chk("rand_drain_busy", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
